// File: rtl/touch_point_qualifier.sv
// Qualifies raw touchpad samples: pressure debounce, power-of-two x/y averaging,
// offset/shift calibration with clamping, and frame-coherent commit of the coordinate pair.
module touch_point_qualifier #(
   parameter int X_OFFSET      = 150,
   parameter int Y_OFFSET      = 300,
   parameter int SHIFT         = 2,
   parameter int X_MAX         = 479,
   parameter int Y_MAX         = 271,
   parameter int Z_THRESH      = 256,
   parameter int PRESS_COUNT   = 4,
   parameter int RELEASE_COUNT = 4,
   parameter int AVG_LOG2      = 2
) (
   input  logic        cclk,
   input  logic        reset,
   input  logic        sample_valid,
   input  logic [11:0] touch_x,
   input  logic [11:0] touch_y,
   input  logic [11:0] touch_z,
   input  logic        new_frame,
   output logic [11:0] locked_x,
   output logic [11:0] locked_y,
   output logic        touch_active,
   output logic        new_point
);

   localparam int SW = 12 + AVG_LOG2;
   localparam int CW = 8;
   localparam logic [CW-1:0] L_PRESS   = CW'(PRESS_COUNT);
   localparam logic [CW-1:0] L_RELEASE = CW'(RELEASE_COUNT);
   localparam logic [CW-1:0] L_BATCH   = CW'(2 ** AVG_LOG2);
   localparam logic [11:0]   L_XOFF    = 12'(X_OFFSET);
   localparam logic [11:0]   L_YOFF    = 12'(Y_OFFSET);
   localparam logic [11:0]   L_XMAX    = 12'(X_MAX);
   localparam logic [11:0]   L_YMAX    = 12'(Y_MAX);
   localparam logic [11:0]   L_ZTH     = 12'(Z_THRESH);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_TRACK    = 2'd2
   } state_t;

   // Average a full window, remove the offset without wrapping, scale, then clamp.
   function automatic logic [11:0] f_calibrate(input logic [SW-1:0] sum,
                                               input logic [11:0]   offset,
                                               input logic [11:0]   max_v);
      logic [11:0] avg;
      logic [11:0] scaled;
      avg = sum[SW-1:AVG_LOG2];
      if (avg < offset) begin
         scaled = 12'd0;
      end else begin
         scaled = (avg - offset) >> SHIFT;
      end
      if (scaled > max_v) begin
         return max_v;
      end else begin
         return scaled;
      end
   endfunction

   state_t         r_state;
   state_t         w_state_nxt;
   logic [CW-1:0]  r_press_cnt, w_press_cnt_nxt;
   logic [CW-1:0]  r_rel_cnt,   w_rel_cnt_nxt;
   logic [CW-1:0]  r_acc_cnt,   w_acc_cnt_nxt;
   logic [SW-1:0]  r_sum_x,     w_sum_x_nxt;
   logic [SW-1:0]  r_sum_y,     w_sum_y_nxt;
   logic           w_batch_done;
   logic           w_release;
   logic [SW-1:0]  w_add_x, w_add_y;
   logic [11:0]    w_cal_x, w_cal_y;
   logic           w_smp_press, w_smp_rel;
   logic [11:0]    r_pend_x, r_pend_y;
   logic           r_pend_valid;
   logic [11:0]    r_locked_x, r_locked_y;
   logic           r_active, r_new_point;
   logic           w_commit;

   assign w_smp_press = sample_valid & (touch_z >= L_ZTH);
   assign w_smp_rel   = sample_valid & (touch_z < L_ZTH);
   // The completing sample is folded in combinationally so pending lands on its own edge.
   assign w_add_x     = r_sum_x + SW'(touch_x);
   assign w_add_y     = r_sum_y + SW'(touch_y);
   assign w_cal_x     = f_calibrate(w_add_x, L_XOFF, L_XMAX);
   assign w_cal_y     = f_calibrate(w_add_y, L_YOFF, L_YMAX);
   assign w_commit    = new_frame & r_pend_valid;

   // State and counter registers.
   always_ff @(posedge cclk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_press_cnt <= {CW{1'b0}};
         r_rel_cnt   <= {CW{1'b0}};
         r_acc_cnt   <= {CW{1'b0}};
         r_sum_x     <= {SW{1'b0}};
         r_sum_y     <= {SW{1'b0}};
      end else begin
         r_state     <= w_state_nxt;
         r_press_cnt <= w_press_cnt_nxt;
         r_rel_cnt   <= w_rel_cnt_nxt;
         r_acc_cnt   <= w_acc_cnt_nxt;
         r_sum_x     <= w_sum_x_nxt;
         r_sum_y     <= w_sum_y_nxt;
      end
   end

   // Debounce / track / release sequencing and accumulation.
   always_comb begin
      w_state_nxt     = r_state;
      w_press_cnt_nxt = r_press_cnt;
      w_rel_cnt_nxt   = r_rel_cnt;
      w_acc_cnt_nxt   = r_acc_cnt;
      w_sum_x_nxt     = r_sum_x;
      w_sum_y_nxt     = r_sum_y;
      w_batch_done    = 1'b0;
      w_release       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_smp_press) begin
               w_press_cnt_nxt = 8'd1;
               w_state_nxt     = S_DEBOUNCE;
            end else begin
               w_press_cnt_nxt = 8'd0;
            end
         end
         S_DEBOUNCE: begin
            if (w_smp_press) begin
               if (r_press_cnt + 8'd1 == L_PRESS) begin
                  w_state_nxt     = S_TRACK;
                  w_press_cnt_nxt = 8'd0;
                  w_rel_cnt_nxt   = 8'd0;
                  w_acc_cnt_nxt   = 8'd0;
                  w_sum_x_nxt     = {SW{1'b0}};
                  w_sum_y_nxt     = {SW{1'b0}};
               end else begin
                  w_press_cnt_nxt = r_press_cnt + 8'd1;
               end
            end else if (w_smp_rel) begin
               w_press_cnt_nxt = 8'd0;
               w_state_nxt     = S_IDLE;
            end else begin
               w_press_cnt_nxt = r_press_cnt;
            end
         end
         S_TRACK: begin
            if (w_smp_press) begin
               w_rel_cnt_nxt = 8'd0;
               if (r_acc_cnt + 8'd1 == L_BATCH) begin
                  w_batch_done  = 1'b1;
                  w_acc_cnt_nxt = 8'd0;
                  w_sum_x_nxt   = {SW{1'b0}};
                  w_sum_y_nxt   = {SW{1'b0}};
               end else begin
                  w_acc_cnt_nxt = r_acc_cnt + 8'd1;
                  w_sum_x_nxt   = w_add_x;
                  w_sum_y_nxt   = w_add_y;
               end
            end else if (w_smp_rel) begin
               if (r_rel_cnt + 8'd1 == L_RELEASE) begin
                  w_release     = 1'b1;
                  w_state_nxt   = S_IDLE;
                  w_rel_cnt_nxt = 8'd0;
                  w_acc_cnt_nxt = 8'd0;
                  w_sum_x_nxt   = {SW{1'b0}};
                  w_sum_y_nxt   = {SW{1'b0}};
               end else begin
                  w_rel_cnt_nxt = r_rel_cnt + 8'd1;
               end
            end else begin
               w_rel_cnt_nxt = r_rel_cnt;
            end
         end
         default: begin
            w_state_nxt     = S_IDLE;
            w_press_cnt_nxt = 8'd0;
            w_rel_cnt_nxt   = 8'd0;
            w_acc_cnt_nxt   = 8'd0;
            w_sum_x_nxt     = {SW{1'b0}};
            w_sum_y_nxt     = {SW{1'b0}};
         end
      endcase
   end

   // Pending pair and frame-synchronous commit to the registered outputs.
   always_ff @(posedge cclk) begin
      if (reset) begin
         r_pend_x     <= 12'd0;
         r_pend_y     <= 12'd0;
         r_pend_valid <= 1'b0;
         r_locked_x   <= 12'd0;
         r_locked_y   <= 12'd0;
         r_active     <= 1'b0;
         r_new_point  <= 1'b0;
      end else if (w_release) begin
         r_pend_valid <= 1'b0;
         r_active     <= 1'b0;
         r_new_point  <= 1'b0;
      end else begin
         r_new_point <= w_commit;
         if (w_commit) begin
            r_locked_x <= r_pend_x;
            r_locked_y <= r_pend_y;
            r_active   <= 1'b1;
         end else begin
            r_active   <= r_active;
         end
         // A fresh batch wins over the clear so it waits for the next frame.
         if (w_batch_done) begin
            r_pend_x     <= w_cal_x;
            r_pend_y     <= w_cal_y;
            r_pend_valid <= 1'b1;
         end else if (w_commit) begin
            r_pend_valid <= 1'b0;
         end else begin
            r_pend_valid <= r_pend_valid;
         end
      end
   end

   assign locked_x     = r_locked_x;
   assign locked_y     = r_locked_y;
   assign touch_active = r_active;
   assign new_point    = r_new_point;

endmodule

// File: tb/tb_touch_point_qualifier.sv
// Directed bench for touch_point_qualifier: calibration vector table plus
// hand-written debounce, release, frame-coherence and reset sequences.
module tb_touch_point_qualifier;

   logic        cclk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_valid = 1'b0;
   logic [11:0] touch_x = 12'd0;
   logic [11:0] touch_y = 12'd0;
   logic [11:0] touch_z = 12'd0;
   logic        new_frame = 1'b0;
   logic [11:0] locked_x, locked_y;
   logic        touch_active, new_point;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      logic [11:0] ex;
      logic [11:0] ey;
   } vec_t;

   vec_t vecs[8];

   touch_point_qualifier dut (
      .cclk(cclk), .reset(reset), .sample_valid(sample_valid),
      .touch_x(touch_x), .touch_y(touch_y), .touch_z(touch_z),
      .new_frame(new_frame), .locked_x(locked_x), .locked_y(locked_y),
      .touch_active(touch_active), .new_point(new_point)
   );

   always #5 cclk = ~cclk;

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic sv, input logic [11:0] x, input logic [11:0] y,
                       input logic [11:0] z, input logic nf);
      sample_valid = sv;
      touch_x = x;
      touch_y = y;
      touch_z = z;
      new_frame = nf;
      @(posedge cclk);
      #1;
      sample_valid = 1'b0;
      new_frame = 1'b0;
   endtask

   task automatic smp(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
      step(1'b1, x, y, z, 1'b0);
   endtask

   task automatic frame();
      step(1'b0, 12'd0, 12'd0, 12'd0, 1'b1);
   endtask

   task automatic idle();
      step(1'b0, 12'd0, 12'd0, 12'd0, 1'b0);
   endtask

   initial begin
      vecs[0] = '{x: 12'd750,  y: 12'd700,  ex: 12'd150, ey: 12'd100};
      vecs[1] = '{x: 12'd100,  y: 12'd4000, ex: 12'd0,   ey: 12'd271};
      vecs[2] = '{x: 12'd4000, y: 12'd300,  ex: 12'd479, ey: 12'd0};
      vecs[3] = '{x: 12'd790,  y: 12'd700,  ex: 12'd160, ey: 12'd100};
      vecs[4] = '{x: 12'd153,  y: 12'd303,  ex: 12'd0,   ey: 12'd0};
      vecs[5] = '{x: 12'd154,  y: 12'd304,  ex: 12'd1,   ey: 12'd1};
      vecs[6] = '{x: 12'd2066, y: 12'd1388, ex: 12'd479, ey: 12'd271};
      vecs[7] = '{x: 12'd2070, y: 12'd1387, ex: 12'd479, ey: 12'd271};

      reset = 1'b1;
      idle();
      idle();
      chk("rst_lx", locked_x, 12'd0);
      chk("rst_ly", locked_y, 12'd0);
      chk("rst_act", {11'd0, touch_active}, 12'd0);
      chk("rst_np", {11'd0, new_point}, 12'd0);
      reset = 1'b0;
      idle();

      // Basic: 4 debounce + 4 accumulated samples, then commit on the next frame.
      for (int i = 0; i < 8; i++) smp(12'd750, 12'd700, 12'd400);
      chk("pre_frame_act", {11'd0, touch_active}, 12'd0);
      chk("pre_frame_np", {11'd0, new_point}, 12'd0);
      frame();
      chk("basic_np", {11'd0, new_point}, 12'd1);
      chk("basic_act", {11'd0, touch_active}, 12'd1);
      chk("basic_lx", locked_x, 12'd150);
      chk("basic_ly", locked_y, 12'd100);
      idle();
      chk("basic_np_pulse", {11'd0, new_point}, 12'd0);

      // Averaging over a non-uniform window.
      for (int i = 0; i < 4; i++) smp(12'(700 + 4 * i), 12'd700, 12'd400);
      frame();
      chk("avg_lx", locked_x, 12'd139);
      chk("avg_ly", locked_y, 12'd100);

      // Calibration table.
      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < 4; i++) smp(vecs[v].x, vecs[v].y, 12'd400);
         frame();
         chk($sformatf("vec%0d_np", v), {11'd0, new_point}, 12'd1);
         chk($sformatf("vec%0d_lx", v), locked_x, vecs[v].ex);
         chk($sformatf("vec%0d_ly", v), locked_y, vecs[v].ey);
         idle();
      end

      // Frame coincident with the pending write defers the commit.
      for (int i = 0; i < 3; i++) smp(12'd750, 12'd700, 12'd400);
      step(1'b1, 12'd750, 12'd700, 12'd400, 1'b1);
      idle();
      chk("coinc_np0", {11'd0, new_point}, 12'd0);
      chk("coinc_lx_hold", locked_x, 12'd479);
      frame();
      chk("coinc_np1", {11'd0, new_point}, 12'd1);
      chk("coinc_lx", locked_x, 12'd150);

      // Two batches before one frame: single commit of the latest.
      for (int i = 0; i < 4; i++) smp(12'd750, 12'd700, 12'd400);
      for (int i = 0; i < 4; i++) smp(12'd790, 12'd700, 12'd400);
      frame();
      chk("twob_np", {11'd0, new_point}, 12'd1);
      chk("twob_lx", locked_x, 12'd160);
      frame();
      chk("twob_no_second", {11'd0, new_point}, 12'd0);

      // 3 unpressed then pressed keeps the touch alive.
      for (int i = 0; i < 3; i++) smp(12'd0, 12'd0, 12'd100);
      smp(12'd750, 12'd700, 12'd400);
      chk("relbreak_act", {11'd0, touch_active}, 12'd1);

      // 4 unpressed end the touch on the 4th edge.
      for (int i = 0; i < 4; i++) begin
         smp(12'd0, 12'd0, 12'd255);
         chk($sformatf("rel%0d_act", i), {11'd0, touch_active}, (i == 3) ? 12'd0 : 12'd1);
         chk($sformatf("rel%0d_np", i), {11'd0, new_point}, 12'd0);
      end
      chk("rel_lx", locked_x, 12'd160);
      chk("rel_ly", locked_y, 12'd100);
      frame();
      chk("rel_frame_np", {11'd0, new_point}, 12'd0);

      // Bounce: never reaches the press count.
      for (int i = 0; i < 40; i++) begin
         smp(12'd750, 12'd700, (i % 4 == 3) ? 12'd100 : 12'd256);
         if (i % 4 == 3) frame();
         chk($sformatf("bounce%0d_act", i), {11'd0, touch_active}, 12'd0);
         chk($sformatf("bounce%0d_np", i), {11'd0, new_point}, 12'd0);
      end

      // Reset in TRACK clears everything including pending.
      for (int i = 0; i < 8; i++) smp(12'd750, 12'd700, 12'd400);
      frame();
      chk("pre_rst_act", {11'd0, touch_active}, 12'd1);
      chk("pre_rst_lx", locked_x, 12'd150);
      for (int i = 0; i < 4; i++) smp(12'd790, 12'd700, 12'd400);
      reset = 1'b1;
      step(1'b1, 12'd750, 12'd700, 12'd400, 1'b1);
      reset = 1'b0;
      chk("mrst_lx", locked_x, 12'd0);
      chk("mrst_ly", locked_y, 12'd0);
      chk("mrst_act", {11'd0, touch_active}, 12'd0);
      chk("mrst_np", {11'd0, new_point}, 12'd0);
      frame();
      chk("mrst_pend_cleared", {11'd0, new_point}, 12'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
